// File: rtl/packet_switch_sdc_fifo_pkg.sv
// Shared constants and elaboration helpers for the classification-result FIFO.
package packet_switch_sdc_fifo_pkg;

  localparam int SDC_FIFO_DEF_DWD       = 32;
  localparam int SDC_FIFO_DEF_NUM_WORDS = 16;
  localparam int SDC_FIFO_MIN_WORDS     = 4;

  // True when n is a non-zero power of two; pointer wrap relies on this.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/packet_switch_sdc_fifo_ram.sv
// Simple dual-port storage: registered write, asynchronous read for show-ahead output.
module packet_switch_sdc_fifo_ram #(
  parameter int    DWD            = 32,
  parameter int    NUM_WORDS      = 16,
  parameter string RAM_BLOCK_TYPE = "MLAB",
  localparam int   AW             = $clog2(NUM_WORDS)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [DWD-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [DWD-1:0] rdata
);

  // Contents are intentionally not reset; only the pointers define validity.
  (* ramstyle = RAM_BLOCK_TYPE *) logic [DWD-1:0] mem [0:NUM_WORDS-1];

  // Write port: store one word per accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/packet_switch_sdc_fifo.sv
// Show-ahead single-clock FIFO buffering per-packet classification results
// (tuple map + header ID) between the parse/classify and lookup stages.
module packet_switch_sdc_fifo
  import packet_switch_sdc_fifo_pkg::*;
#(
  parameter int    DWD            = SDC_FIFO_DEF_DWD,
  parameter int    NUM_WORDS      = SDC_FIFO_DEF_NUM_WORDS,
  parameter string RAM_BLOCK_TYPE = "MLAB",
  localparam int   AW             = $clog2(NUM_WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DWD-1:0] din,
  input  logic           wrreq,
  input  logic           rdreq,
  output logic [DWD-1:0] dout,
  output logic           rdempty,
  output logic           rdempty_lkahd,
  output logic           wrfull,
  output logic [AW-1:0]  wrusedw,
  output logic           overflow,
  output logic           underflow
);

  localparam int PW = AW + 1;

  if (!is_pow2(NUM_WORDS) || (NUM_WORDS < SDC_FIFO_MIN_WORDS)) begin : g_bad_depth
    $error("packet_switch_sdc_fifo: NUM_WORDS must be a power of two and at least 4");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [PW-1:0] count_nxt;
  logic [AW-1:0] usedw_nxt;
  logic          wr_ok;
  logic          rd_ok;

  // Pointers wrap modulo NUM_WORDS through their low bits; the top bit is spare.
  logic unused_ptr_msb;
  assign unused_ptr_msb = wr_ptr[AW] ^ rd_ptr[AW];

  // Acceptance is judged against the registered flags, so a write while full
  // is dropped even when a pop happens in the same cycle.
  assign wr_ok = wrreq & ~wrfull;
  assign rd_ok = rdreq & ~rdempty;

  assign count_nxt = count + PW'(wr_ok) - PW'(rd_ok);

  // The port cannot represent NUM_WORDS, so a full FIFO reports all ones.
  assign usedw_nxt = (count_nxt == PW'(NUM_WORDS)) ? {AW{1'b1}} : count_nxt[AW-1:0];

  // Empty next cycle unless a write arrives now.
  assign rdempty_lkahd = ((count == PW'(0)) & ~wrreq) |
                         ((count == PW'(1)) & rd_ok & ~wrreq);

  packet_switch_sdc_fifo_ram #(
    .DWD            (DWD),
    .NUM_WORDS      (NUM_WORDS),
    .RAM_BLOCK_TYPE (RAM_BLOCK_TYPE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout)
  );

  // Pointer, occupancy, status-flag and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rdempty   <= 1'b1;
      wrfull    <= 1'b0;
      wrusedw   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count     <= count_nxt;
      rdempty   <= (count_nxt == PW'(0));
      wrfull    <= (count_nxt == PW'(NUM_WORDS));
      wrusedw   <= usedw_nxt;
      overflow  <= wrreq & wrfull;
      underflow <= rdreq & rdempty;
    end
  end

endmodule

// File: tb/tb_packet_switch_sdc_fifo.sv
// Self-checking bench for packet_switch_sdc_fifo: directed vector table plus
// queue scoreboard for data ordering and a reference occupancy model.
module tb_packet_switch_sdc_fifo;

  localparam int DWD = 32;
  localparam int NW  = 16;
  localparam int AW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [DWD-1:0] din;
  logic           wrreq;
  logic           rdreq;
  logic [DWD-1:0] dout;
  logic           rdempty;
  logic           rdempty_lkahd;
  logic           wrfull;
  logic [AW-1:0]  wrusedw;
  logic           overflow;
  logic           underflow;

  always #5 clk = ~clk;

  packet_switch_sdc_fifo #(
    .DWD            (DWD),
    .NUM_WORDS      (NW),
    .RAM_BLOCK_TYPE ("MLAB")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .wrreq         (wrreq),
    .rdreq         (rdreq),
    .dout          (dout),
    .rdempty       (rdempty),
    .rdempty_lkahd (rdempty_lkahd),
    .wrfull        (wrfull),
    .wrusedw       (wrusedw),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  int checks = 0;
  int errors = 0;

  logic [DWD-1:0] sb[$];
  int             m_count = 0;
  bit             m_ovf   = 1'b0;
  bit             m_unf   = 1'b0;

  typedef struct {
    bit             wr;
    bit             rd;
    logic [DWD-1:0] d;
    bit             exp_lk;
    bit             exp_empty;
    bit             exp_full;
    logic [AW-1:0]  exp_usedw;
    bit             exp_ovf;
    bit             exp_unf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [DWD-1:0] act, input logic [DWD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Registered outputs against the reference model, sampled at the falling edge.
  task automatic check_state(input string tag);
    logic [AW-1:0] exp_usedw;
    exp_usedw = (m_count == NW) ? 4'hF : AW'(m_count);
    check({tag, " rdempty"},   32'(rdempty),   32'(m_count == 0));
    check({tag, " wrfull"},    32'(wrfull),    32'(m_count == NW));
    check({tag, " wrusedw"},   32'(wrusedw),   32'(exp_usedw));
    check({tag, " overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(m_unf));
    if (m_count > 0) check({tag, " dout head"}, dout, sb[0]);
  endtask

  // One clock: drive inputs at the falling edge, check look-ahead and popped
  // data before the rising edge, then check registered state after it.
  task automatic cycle(input bit wr, input bit rd, input logic [DWD-1:0] d, input string tag);
    bit wok, rok, exp_lk;
    logic [DWD-1:0] exp_d;
    wrreq = wr;
    rdreq = rd;
    din   = d;
    #1;
    wok    = wr && (m_count < NW);
    rok    = rd && (m_count > 0);
    exp_lk = ((m_count == 0) && !wr) || ((m_count == 1) && rok && !wr);
    check({tag, " rdempty_lkahd"}, 32'(rdempty_lkahd), 32'(exp_lk));
    if (rok) begin
      exp_d = sb.pop_front();
      check({tag, " pop data"}, dout, exp_d);
    end
    if (wok) sb.push_back(d);
    m_ovf   = wr && (m_count == NW);
    m_unf   = rd && (m_count == 0);
    m_count = m_count + int'(wok) - int'(rok);
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    check_state("reset");
  endtask

  initial begin
    rst   = 1'b1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    din   = '0;

    //          wr rd data           lk empty full usedw ovf unf
    vecs[0] = '{0, 0, 32'h0,          1, 1,    0,   4'd0, 0,  0};
    vecs[1] = '{1, 0, 32'hA5A5_0001,  0, 0,    0,   4'd1, 0,  0};
    vecs[2] = '{0, 1, 32'h0,          1, 1,    0,   4'd0, 0,  0};
    vecs[3] = '{0, 1, 32'h0,          1, 1,    0,   4'd0, 0,  1};
    vecs[4] = '{1, 1, 32'hBEEF_0002,  0, 0,    0,   4'd1, 0,  1};
    vecs[5] = '{0, 0, 32'h0,          0, 0,    0,   4'd1, 0,  0};
    vecs[6] = '{1, 1, 32'h0000_0003,  0, 0,    0,   4'd1, 0,  0};
    vecs[7] = '{0, 1, 32'h0,          1, 1,    0,   4'd0, 0,  0};

    @(negedge clk);
    do_reset();

    // Directed table: single write/pop, underflow, write+read while empty.
    for (int i = 0; i < 8; i++) begin
      wrreq = vecs[i].wr;
      rdreq = vecs[i].rd;
      din   = vecs[i].d;
      #1;
      check($sformatf("vec%0d lkahd", i), 32'(rdempty_lkahd), 32'(vecs[i].exp_lk));
      #0;
      @(negedge clk);
      check($sformatf("vec%0d rdempty", i),   32'(rdempty),   32'(vecs[i].exp_empty));
      check($sformatf("vec%0d wrfull", i),    32'(wrfull),    32'(vecs[i].exp_full));
      check($sformatf("vec%0d wrusedw", i),   32'(wrusedw),   32'(vecs[i].exp_usedw));
      check($sformatf("vec%0d overflow", i),  32'(overflow),  32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
      if (i == 1) check("vec1 dout", dout, 32'hA5A5_0001);
      if (i == 4 || i == 5) check($sformatf("vec%0d dout", i), dout, 32'hBEEF_0002);
      if (i == 6) check("vec6 dout", dout, 32'h0000_0003);
    end

    // Fill to full, overflow, write+read while full, then drain in order.
    for (int i = 0; i < NW; i++) cycle(1'b1, 1'b0, DWD'(i), "fill");
    check("full wrusedw", 32'(wrusedw), 32'h0000_000F);
    check("full wrfull",  32'(wrfull),  32'h1);
    cycle(1'b1, 1'b0, 32'hDEAD_0099, "overflow");
    check("overflow pulse", 32'(overflow), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, "overflow idle");
    check("overflow one cycle", 32'(overflow), 32'h0);
    check("overflow head", dout, 32'h0);
    cycle(1'b1, 1'b1, 32'hDEAD_0077, "wr_rd_full");
    check("wr_rd_full usedw", 32'(wrusedw), 32'd15);
    for (int i = 1; i < NW; i++) cycle(1'b0, 1'b1, 32'h0, "drain");
    cycle(1'b0, 1'b1, 32'h0, "drain_underflow");

    // Streaming: one primed word, then simultaneous write/read each cycle.
    cycle(1'b1, 1'b0, 32'h0000_1000, "prime");
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 32'h0000_1001 + DWD'(i), "stream");
    check("stream usedw", 32'(wrusedw), 32'd1);
    cycle(1'b0, 1'b1, 32'h0, "stream tail");

    // Reset with data inside: contents are discarded, no stale word appears.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h5000_0000 + DWD'(i), "prefill");
    do_reset();
    check("post-reset rdempty", 32'(rdempty), 32'h1);
    check("post-reset wrusedw", 32'(wrusedw), 32'h0);
    cycle(1'b1, 1'b0, 32'h0000_1234, "post-reset write");
    check("post-reset dout", dout, 32'h0000_1234);
    cycle(1'b0, 1'b1, 32'h0, "post-reset pop");

    // Random mix to exercise wrap and flag transitions.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_switch_sdc_fifo.md
Name:
packet_switch_sdc_fifo

Overview:
- Single-clock-domain, show-ahead (first-word-fall-through) synchronous FIFO with a parameterizable width and depth.
- Used in the packet-switch parse/classify path to buffer per-packet classification results (tuple map plus header ID) until the lookup stage pops them.
- Provides occupancy, full/empty, look-ahead empty and overflow/underflow error flags.

Parameters:
- DWD, 32: data width in bits.
- NUM_WORDS, 16: depth in words. Must be a power of two, at least 4.
- RAM_BLOCK_TYPE, "MLAB": RAM style synthesis attribute for the storage array. It has no functional effect.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  DWD  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read/pop request. It acknowledges the word currently on dout.
- dout  out  DWD  head-of-FIFO data. Valid whenever rdempty=0.
- rdempty  out  1  FIFO empty.
- rdempty_lkahd  out  1  FIFO will be empty on the next cycle.
- wrfull  out  1  FIFO holds NUM_WORDS words.
- wrusedw  out  $clog2(NUM_WORDS)  occupancy.
- overflow  out  1  one-cycle pulse: write was dropped.
- underflow  out  1  one-cycle pulse: read was made while empty.

Behaviour:
- Storage and pointers:
  - Storage: NUM_WORDS x DWD array.
  - Write pointer, read pointer and count are registered, each $clog2(NUM_WORDS)+1 bits internally.
  - Pointers wrap modulo NUM_WORDS.
- Reset:
  - Pointers and count = 0.
  - rdempty=1, rdempty_lkahd=1, wrfull=0, wrusedw=0, overflow=0, underflow=0.
  - The storage array is not reset. dout is undefined while rdempty=1.
- Write accept: wr_ok = wrreq & ~wrfull.
  - The write is evaluated against the registered full flag, so a write while full is dropped even if a read happens in the same cycle.
  - An accepted write stores din at the write pointer and increments the pointer.
- Read accept: rd_ok = rdreq & ~rdempty.
  - An accepted read increments the read pointer.
- Count and flags:
  - Next-cycle count = count + wr_ok - rd_ok.
  - rdempty and wrfull are registered from the next-cycle count (==0 and ==NUM_WORDS respectively).
- Show-ahead output:
  - dout = storage[read pointer], asynchronous read.
  - A word written in cycle N appears on dout, with rdempty=0, in cycle N+1. Write-to-read latency is 1 cycle.
  - After a pop, the next word is on dout in the following cycle, so back-to-back pops at full rate are supported.
- wrusedw:
  - Equals count while count < NUM_WORDS.
  - When full it saturates at NUM_WORDS-1 (all ones), because the port width cannot represent NUM_WORDS. Use wrfull to tell 15 words from 16 words.
  - Registered, same timing as rdempty.
- rdempty_lkahd (combinational):
  - Asserted when (count==0 & ~wrreq) or (count==1 & rd_ok & ~wrreq).
  - That is, the FIFO is empty next cycle when no write arrives.
- overflow: registered. Asserted the cycle after wrreq & wrfull.
- underflow: registered. Asserted the cycle after rdreq & rdempty.
- Simultaneous events:
  - Write and read when not empty and not full: both are performed, count is unchanged, data order is preserved.
  - Write and read while empty: the read is an underflow, the write is accepted, and count becomes 1.
  - Write and read while full: the write is dropped (overflow), the read is accepted, and count becomes NUM_WORDS-1.
- Reset mid-operation: all contents are discarded; the FIFO is empty in the cycle after rst is sampled high.
- Upstream flow control is done externally using wrusedw (e.g. tready = wrusedw < NUM_WORDS-8). The FIFO itself never backpressures except by dropping writes when full.

Decomposition:
- Single module, no submodules.
- No package types are required. The parent packs its struct types (tuple_map_S, HDR_ID_e) into din/dout; their widths (tuple_map_width, hdr_id_width) live in packet_switch_pkg / packet_switch_hdr_pkg.
- The storage array may be split into a small generic RAM sub-module, sdc_fifo_ram, carrying the ramstyle attribute.

Test Plan:
- Reset then idle -> rdempty=1, wrfull=0, wrusedw=0, rdempty_lkahd=1, no error pulses.
- Single write of din=32'hA5A5_0001 at cycle N -> cycle N+1: rdempty=0, dout=32'hA5A5_0001, wrusedw=1. A pop at N+1 -> cycle N+2: rdempty=1.
- Write 16 words (values 0..15) with no reads -> wrfull=1, wrusedw=4'hF. A 17th write -> overflow pulses 1 cycle, count stays 16. Reading 16 words then returns 0..15 in order.
- Continuous write and read each cycle after priming 1 word, for 100 cycles -> wrusedw holds at 1, data in order, no flags.
- rdreq while empty -> underflow pulses for 1 cycle, pointers unchanged. Simultaneous wrreq while empty -> word accepted, wrusedw=1.
- Fill 5 words, assert rst for 1 cycle -> next cycle rdempty=1 and wrusedw=0. A new write of 32'h1234 afterwards appears on dout with no stale data.
